mem: RTL and testbench

Memory stage of the multithreaded pipeline. It sits between `exe` and write-back, receives the execute-stage register bundle (`*_mem`), and performs word loads and stores over a req/ack data-memory port that may take several cycles. It issues thread-control operations to the thread scheduler and registers the write-back bundle (`*_wb`) that `exe` consumes for forwarding. While a memory access is outstanding it raises `stall_mem`.

---
 rtl/mem_if.sv | 21 ++
 rtl/mem.sv | 164 ++++++++++++++++
 tb/tb_mem.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_if.sv
// Data-memory request/acknowledge port used by the mem stage.
// The mem stage is the master; the memory side acknowledges in the cycle the access finishes.
// At most one request is outstanding. The request fields stay stable until the ack.
interface mem_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem.sv
// Memory stage: word loads/stores over a req/ack port, thread-control issue, registered write-back bundle.
// Latency: *_wb outputs are valid 1 cycle after a completion (a non-memory op, or the memory ack).
// Backpressure: stall_mem = dmem_req & !dmem_ack holds upstream; MEM_TIMEOUT_EN bounds the ack wait to TIMEOUT cycles.
module mem #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_mem,
  input  logic [31:0] ins_mem,
  input  logic [31:0] pc_mem,
  input  logic [31:0] exe_data_mem,
  input  logic [2:0]  trd_mem,
  input  logic [4:0]  reg_wr_mem,
  input  logic        wr_en_mem,
  input  logic        wb_sel_mem,
  input  logic [1:0]  mem_ctrl_mem,
  input  logic [1:0]  trd_ctrl_mem,
  input  logic [2:0]  obj_trd_mem,
  input  logic        flushMEM,
  mem_if.master       dmem,
  output logic        trd_op_vld,
  output logic [1:0]  trd_op,
  output logic [2:0]  trd_op_tgt,
  output logic [31:0] ins_wb,
  output logic [31:0] pc_wb,
  output logic [31:0] wb_data_wb,
  output logic [2:0]  trd_wb,
  output logic [4:0]  reg_wr_wb,
  output logic        wr_en_wb,
  output logic        stall_mem,
  output logic        misalign_mem,
  output logic        timeout_mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state;

  logic is_mem_op;
  logic aligned;
  logic mem_ins;
  logic misaligned;
  logic issue_now;
  logic req;
  logic ack;
  logic timeout_hit;
  logic complete;
  logic load_wb;

  assign is_mem_op  = |mem_ctrl_mem;
  assign aligned    = (addr_mem[1:0] == 2'b00);
  assign mem_ins    = is_mem_op & aligned;
  assign misaligned = is_mem_op & ~aligned;

  // A flushed instruction in IDLE never starts an access, so IDLE never moves to DROP directly.
  assign issue_now = (state == IDLE) & mem_ins & ~flushMEM;

  // Gated by rst_n so an access in flight is abandoned the instant reset asserts.
  assign req = rst_n & (issue_now | ((state != IDLE) & ~timeout_hit));
  assign ack = req & dmem.dmem_ack;

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = req & mem_ctrl_mem[1];
  assign dmem.dmem_addr  = req ? {addr_mem[31:2], 2'b00} : 32'd0;
  assign dmem.dmem_wdata = req ? exe_data_mem : 32'd0;

  assign stall_mem = req & ~dmem.dmem_ack;

  // A DROP completion has its side effects in memory but never reaches write-back.
  assign complete = ((state == IDLE) & ~is_mem_op) | ((state != DROP) & ack);
  assign load_wb  = complete & ~flushMEM;

`ifdef MEM_TIMEOUT_EN
  // Optional feature macro: MEM_TIMEOUT_EN bounds the ack wait.
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] wait_cnt;
  logic          timeout_q;

  // The count is the number of request cycles so far without an ack.
  assign timeout_hit = (state != IDLE) & (wait_cnt == CW'(TIMEOUT));
  assign timeout_mem = timeout_q;

  // Count unacknowledged request cycles; restart on every new access and on ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (state == IDLE) begin
        wait_cnt <= (issue_now & ~dmem.dmem_ack) ? CW'(1) : '0;
      end else if (ack | timeout_hit) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_mem = 1'b0;
`endif

  // Access state machine: wait for the ack; DROP finishes a flushed access silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (issue_now & ~dmem.dmem_ack) state <= WAIT;
        end
        WAIT: begin
          if (ack | timeout_hit) state <= IDLE;
          else if (flushMEM)     state <= DROP;
        end
        DROP: begin
          if (ack | timeout_hit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write-back bundle, thread-op pulse and misalign pulse; a bubble clears only the enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_wb       <= 32'd0;
      pc_wb        <= 32'd0;
      wb_data_wb   <= 32'd0;
      trd_wb       <= 3'd0;
      reg_wr_wb    <= 5'd0;
      wr_en_wb     <= 1'b0;
      trd_op_vld   <= 1'b0;
      trd_op       <= 2'd0;
      trd_op_tgt   <= 3'd0;
      misalign_mem <= 1'b0;
    end else begin
      wr_en_wb     <= 1'b0;
      trd_op_vld   <= 1'b0;
      misalign_mem <= (state == IDLE) & misaligned & ~flushMEM;
      if (load_wb) begin
        ins_wb     <= ins_mem;
        pc_wb      <= pc_mem;
        wb_data_wb <= wb_sel_mem ? dmem.dmem_rdata : exe_data_mem;
        trd_wb     <= trd_mem;
        reg_wr_wb  <= reg_wr_mem;
        wr_en_wb   <= wr_en_mem & (|reg_wr_mem);
        if (|trd_ctrl_mem) begin
          trd_op_vld <= 1'b1;
          trd_op     <= trd_ctrl_mem;
          trd_op_tgt <= obj_trd_mem;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for mem: directed scenarios plus a randomized mix against a transaction-level model.
// Each instruction is driven, its memory access serviced with a chosen ack latency, then write-back is compared.
// The model tracks only what write-back must show after each instruction, derived from the stage's rules.
`timescale 1ns/1ps
module tb_mem;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] data;
    logic [2:0]  trd;
    logic [4:0]  rd;
    logic        wr_en;
    logic        wb_sel;
    logic [1:0]  mctl;
    logic [1:0]  tctl;
    logic [2:0]  obj;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr_mem = '0, ins_mem = '0, pc_mem = '0, exe_data_mem = '0;
  logic [2:0]  trd_mem = '0, obj_trd_mem = '0;
  logic [4:0]  reg_wr_mem = '0;
  logic        wr_en_mem = 1'b0, wb_sel_mem = 1'b0, flushMEM = 1'b0;
  logic [1:0]  mem_ctrl_mem = '0, trd_ctrl_mem = '0;
  logic        trd_op_vld, wr_en_wb, stall_mem, misalign_mem, timeout_mem;
  logic [1:0]  trd_op;
  logic [2:0]  trd_op_tgt, trd_wb;
  logic [31:0] ins_wb, pc_wb, wb_data_wb;
  logic [4:0]  reg_wr_wb;

  mem_if dmem();

  mem #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_mem(addr_mem), .ins_mem(ins_mem), .pc_mem(pc_mem), .exe_data_mem(exe_data_mem),
    .trd_mem(trd_mem), .reg_wr_mem(reg_wr_mem), .wr_en_mem(wr_en_mem), .wb_sel_mem(wb_sel_mem),
    .mem_ctrl_mem(mem_ctrl_mem), .trd_ctrl_mem(trd_ctrl_mem), .obj_trd_mem(obj_trd_mem),
    .flushMEM(flushMEM), .dmem(dmem),
    .trd_op_vld(trd_op_vld), .trd_op(trd_op), .trd_op_tgt(trd_op_tgt),
    .ins_wb(ins_wb), .pc_wb(pc_wb), .wb_data_wb(wb_data_wb), .trd_wb(trd_wb),
    .reg_wr_wb(reg_wr_wb), .wr_en_wb(wr_en_wb), .stall_mem(stall_mem),
    .misalign_mem(misalign_mem), .timeout_mem(timeout_mem)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected write-back view after the last instruction.
  logic [31:0] m_ins, m_pc, m_data;
  logic [2:0]  m_trd, m_ttgt;
  logic [4:0]  m_reg;
  logic [1:0]  m_top;
  logic        m_wren, m_tvld, m_mis;

  // Observations from the last issue.
  int obs_req, obs_stall, obs_bad;

  task automatic model_reset();
    m_ins = '0; m_pc = '0; m_data = '0; m_trd = '0; m_ttgt = '0;
    m_reg = '0; m_top = '0; m_wren = 1'b0; m_tvld = 1'b0; m_mis = 1'b0;
  endtask

  // Write-back effect of one instruction: bubble if flushed or misaligned, else a full update.
  task automatic model_apply(input instr_t in, input logic flushed, input logic [31:0] rd);
    logic mis;
    mis   = (in.mctl != 2'b00) && (in.addr[1:0] != 2'b00);
    m_mis = mis && !flushed;
    if (flushed || mis) begin
      m_wren = 1'b0;
      m_tvld = 1'b0;
    end else begin
      m_ins  = in.ins;
      m_pc   = in.pc;
      m_trd  = in.trd;
      m_reg  = in.rd;
      m_data = in.wb_sel ? rd : in.data;
      m_wren = in.wr_en && (in.rd != 5'd0);
      m_tvld = (in.tctl != 2'b00);
      if (m_tvld) begin
        m_top  = in.tctl;
        m_ttgt = in.obj;
      end
    end
  endtask

  task automatic drive(input instr_t in);
    addr_mem = in.addr; ins_mem = in.ins; pc_mem = in.pc; exe_data_mem = in.data;
    trd_mem = in.trd; reg_wr_mem = in.rd; wr_en_mem = in.wr_en; wb_sel_mem = in.wb_sel;
    mem_ctrl_mem = in.mctl; trd_ctrl_mem = in.tctl; obj_trd_mem = in.obj;
  endtask

  // Present one instruction, acknowledge its access lat cycles after the request, flush in cycle flush_cyc (-1 none).
  // Returns at #1 after the edge that registers the result.
  task automatic issue(input instr_t in, input int lat, input int flush_cyc, input logic [31:0] rd);
    logic will_req;
    int   ncyc;
    drive(in);
    will_req = (in.mctl != 2'b00) && (in.addr[1:0] == 2'b00) && (flush_cyc != 0);
    ncyc = will_req ? lat + 1 : 1;
    obs_req = 0; obs_stall = 0; obs_bad = 0;
    for (int k = 0; k < ncyc; k++) begin
      flushMEM = (k == flush_cyc);
      dmem.dmem_ack = will_req && (k == lat);
      dmem.dmem_rdata = (will_req && k == lat) ? rd : $urandom;
      @(negedge clk);
      obs_req += int'(dmem.dmem_req);
      obs_stall += int'(stall_mem);
      if (will_req && (dmem.dmem_addr !== {in.addr[31:2], 2'b00} || dmem.dmem_we !== in.mctl[1] ||
                       dmem.dmem_wdata !== in.data))
        obs_bad++;
      @(posedge clk); #1;
    end
    dmem.dmem_ack = 1'b0;
    flushMEM = 1'b0;
    model_apply(in, (flush_cyc >= 0) && (flush_cyc < ncyc), rd);
  endtask

  function automatic instr_t rand_instr(input int kind);
    instr_t in;
    in = '0;
    in.ins = $urandom; in.pc = $urandom; in.data = $urandom;
    in.trd = 3'($urandom); in.rd = 5'($urandom); in.wr_en = 1'($urandom);
    in.tctl = 2'($urandom); in.obj = 3'($urandom);
    if ($urandom_range(0, 5) == 0) in.rd = 5'd0;
    in.addr = {$urandom} & 32'hFFFF_FFFC;
    case (kind)
      1: begin in.mctl = 2'b01; in.wb_sel = 1'b1; end
      2: begin in.mctl = 2'b10; end
      3: begin in.mctl = 2'($urandom_range(1, 3)); in.addr[1:0] = 2'($urandom_range(1, 3)); end
      default: ;
    endcase
    return in;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({dmem.dmem_req, dmem.dmem_we, stall_mem, wr_en_wb, trd_op_vld, misalign_mem, timeout_mem} !== 7'd0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0", {dmem.dmem_req, dmem.dmem_we, stall_mem, wr_en_wb, trd_op_vld, misalign_mem, timeout_mem});
    end
    checks++;
    if ({ins_wb, pc_wb, wb_data_wb} !== 96'd0) begin
      errors++; $display("FAIL reset_wb_words: got %h expected 0", {ins_wb, pc_wb, wb_data_wb});
    end
    checks++;
    if ({dmem.dmem_addr, dmem.dmem_wdata, trd_wb, reg_wr_wb, trd_op, trd_op_tgt} !== 77'd0) begin
      errors++; $display("FAIL reset_fields: got %h expected 0", {dmem.dmem_addr, dmem.dmem_wdata, trd_wb, reg_wr_wb, trd_op, trd_op_tgt});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_alu();
    instr_t in;
    in = rand_instr(0);
    in.data = 32'h1234; in.rd = 5'd5; in.wr_en = 1'b1; in.wb_sel = 1'b0; in.tctl = 2'b00;
    issue(in, 0, -1, 32'h0);
    checks++;
    if (wb_data_wb !== 32'h1234 || reg_wr_wb !== 5'd5 || wr_en_wb !== 1'b1) begin
      errors++; $display("FAIL alu_wb: got data=%h reg=%0d en=%b expected data=1234 reg=5 en=1", wb_data_wb, reg_wr_wb, wr_en_wb);
    end
    checks++;
    if (obs_req !== 0) begin
      errors++; $display("FAIL alu_no_req: got %0d req cycles expected 0", obs_req);
    end
    checks++;
    if (ins_wb !== in.ins || pc_wb !== in.pc || trd_wb !== in.trd) begin
      errors++; $display("FAIL alu_pass: got ins=%h pc=%h trd=%0d expected ins=%h pc=%h trd=%0d", ins_wb, pc_wb, trd_wb, in.ins, in.pc, in.trd);
    end
  endtask

  task automatic test_load_wait();
    instr_t in;
    in = rand_instr(1);
    in.addr = 32'h100; in.rd = 5'd7; in.wr_en = 1'b1; in.tctl = 2'b00;
    issue(in, 3, -1, 32'hDEADBEEF);
    checks++;
    if (obs_stall !== 3 || obs_req !== 4) begin
      errors++; $display("FAIL load_stall: got stall=%0d req=%0d expected stall=3 req=4", obs_stall, obs_req);
    end
    checks++;
    if (obs_bad !== 0) begin
      errors++; $display("FAIL load_fields: got %0d unstable cycles expected 0", obs_bad);
    end
    checks++;
    if (wb_data_wb !== 32'hDEADBEEF || wr_en_wb !== 1'b1) begin
      errors++; $display("FAIL load_wb: got %h en=%b expected deadbeef en=1", wb_data_wb, wr_en_wb);
    end
  endtask

  task automatic test_store_zero_wait();
    instr_t in;
    in = rand_instr(2);
    in.addr = 32'h104; in.data = 32'hA5A5A5A5; in.tctl = 2'b00;
    issue(in, 0, -1, $urandom);
    checks++;
    if (obs_req !== 1 || obs_stall !== 0 || obs_bad !== 0) begin
      errors++; $display("FAIL store_zero_wait: got req=%0d stall=%0d bad=%0d expected 1 0 0", obs_req, obs_stall, obs_bad);
    end
  endtask

  task automatic test_misaligned();
    instr_t in;
    in = rand_instr(2);
    in.addr = 32'h102; in.wr_en = 1'b1; in.rd = 5'd3; in.tctl = 2'b01;
    issue(in, 0, -1, 32'h0);
    checks++;
    if (obs_req !== 0 || misalign_mem !== 1'b1 || wr_en_wb !== 1'b0 || trd_op_vld !== 1'b0) begin
      errors++; $display("FAIL misalign: got req=%0d mis=%b en=%b tvld=%b expected 0 1 0 0", obs_req, misalign_mem, wr_en_wb, trd_op_vld);
    end
    issue('0, 0, -1, 32'h0);
    checks++;
    if (misalign_mem !== 1'b0) begin
      errors++; $display("FAIL misalign_pulse: got %b expected 0", misalign_mem);
    end
  endtask

  task automatic test_flush_thread();
    instr_t in;
    logic [31:0] prev_data;
    in = rand_instr(1);
    in.rd = 5'd9; in.wr_en = 1'b1; in.tctl = 2'b01; in.obj = 3'd3;
    prev_data = m_data;
    issue(in, 3, 1, 32'h600D_F00D);
    checks++;
    if (obs_req !== 4 || wr_en_wb !== 1'b0 || trd_op_vld !== 1'b0 || wb_data_wb !== prev_data) begin
      errors++; $display("FAIL flush_wait: got req=%0d en=%b tvld=%b data=%h expected 4 0 0 %h", obs_req, wr_en_wb, trd_op_vld, wb_data_wb, prev_data);
    end
    issue(in, 2, -1, 32'h600D_F00D);
    checks++;
    if (trd_op_vld !== 1'b1 || trd_op !== 2'b01 || trd_op_tgt !== 3'd3 || wr_en_wb !== 1'b1) begin
      errors++; $display("FAIL thread_op: got vld=%b op=%b tgt=%0d en=%b expected 1 01 3 1", trd_op_vld, trd_op, trd_op_tgt, wr_en_wb);
    end
    issue('0, 0, -1, 32'h0);
    checks++;
    if (trd_op_vld !== 1'b0) begin
      errors++; $display("FAIL thread_op_pulse: got %b expected 0", trd_op_vld);
    end
  endtask

  task automatic test_back_to_back();
    int start;
    start = cyc;
    for (int i = 0; i < 8; i++) begin
      issue(rand_instr(0), 0, -1, 32'h0);
      checks++;
      if (wr_en_wb !== m_wren || wb_data_wb !== m_data || reg_wr_wb !== m_reg || trd_op_vld !== m_tvld) begin
        errors++; $display("FAIL b2b_%0d: got en=%b data=%h reg=%0d tvld=%b expected %b %h %0d %b", i, wr_en_wb, wb_data_wb, reg_wr_wb, trd_op_vld, m_wren, m_data, m_reg, m_tvld);
      end
    end
    checks++;
    if (cyc - start !== 8) begin
      errors++; $display("FAIL b2b_throughput: got %0d cycles expected 8", cyc - start);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      instr_t in;
      int kind, lat, fc, exp_req;
      kind = $urandom_range(0, 3);
      lat  = $urandom_range(0, 4);
      fc   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat) : -1;
      in   = rand_instr(kind);
      exp_req = ((kind == 1 || kind == 2) && fc != 0) ? lat + 1 : 0;
      issue(in, lat, fc, $urandom);
      checks++;
      if (obs_req !== exp_req || obs_stall !== (exp_req == 0 ? 0 : lat) || obs_bad !== 0) begin
        errors++; $display("FAIL rand_%0d_mem: got req=%0d stall=%0d bad=%0d expected req=%0d stall=%0d bad=0", i, obs_req, obs_stall, obs_bad, exp_req, (exp_req == 0 ? 0 : lat));
      end
      checks++;
      if ({ins_wb, pc_wb, wb_data_wb, trd_wb, reg_wr_wb, wr_en_wb} !== {m_ins, m_pc, m_data, m_trd, m_reg, m_wren}) begin
        errors++; $display("FAIL rand_%0d_wb: got %h expected %h", i, {ins_wb, pc_wb, wb_data_wb, trd_wb, reg_wr_wb, wr_en_wb}, {m_ins, m_pc, m_data, m_trd, m_reg, m_wren});
      end
      checks++;
      if (trd_op_vld !== m_tvld || misalign_mem !== m_mis || (m_tvld && {trd_op, trd_op_tgt} !== {m_top, m_ttgt})) begin
        errors++; $display("FAIL rand_%0d_ctl: got tvld=%b mis=%b op=%b tgt=%0d expected %b %b %b %0d", i, trd_op_vld, misalign_mem, trd_op, trd_op_tgt, m_tvld, m_mis, m_top, m_ttgt);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    instr_t in;
    in = rand_instr(1);
    drive(in);
    dmem.dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (dmem.dmem_req !== 1'b1 || stall_mem !== 1'b1) begin
      errors++; $display("FAIL midwait_pending: got req=%b stall=%b expected 1 1", dmem.dmem_req, stall_mem);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dmem.dmem_req, dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata, stall_mem, wr_en_wb, wb_data_wb, ins_wb, pc_wb, trd_op_vld, misalign_mem, timeout_mem} !== '0) begin
      errors++; $display("FAIL midwait_reset: got req=%b stall=%b en=%b data=%h expected all 0", dmem.dmem_req, stall_mem, wr_en_wb, wb_data_wb);
    end
    drive('0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    issue('0, 0, -1, 32'h0);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    instr_t in;
    int reqs, pulses, wens;
    logic dropped;
    in = rand_instr(1);
    in.wr_en = 1'b1; in.rd = 5'd4;
    drive(in);
    dmem.dmem_ack = 1'b0;
    reqs = 0; pulses = 0; wens = 0; dropped = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dmem.dmem_req === 1'b1) reqs++;
      else dropped = 1'b1;
      if (timeout_mem === 1'b1) pulses++;
      if (wr_en_wb === 1'b1) wens++;
      @(posedge clk); #1;
      if (dropped) drive('0);
    end
    checks++;
    if (reqs !== 4 || pulses !== 1 || wens !== 0) begin
      errors++; $display("FAIL timeout: got req=%0d pulses=%0d wr_en=%0d expected 4 1 0", reqs, pulses, wens);
    end
    issue('0, 0, -1, 32'h0);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    dmem.dmem_ack = 1'b0;
    dmem.dmem_rdata = 32'h0;
    model_reset();
    test_reset();
    test_alu();
    test_load_wait();
    test_store_zero_wait();
    test_misaligned();
    test_flush_thread();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
